// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : ALU operation codes and memory access-size constants for the
//           MIPS execute/memory datapath slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;
   localparam logic [3:0] ALU_ADDU = 4'b1100;
   localparam logic [3:0] ALU_SUBU = 4'b1101;
   localparam logic [3:0] ALU_SLLV = 4'b1110;
   localparam logic [3:0] ALU_SRLV = 4'b1111;

   localparam logic MEM_WORD = 1'b0;
   localparam logic MEM_BYTE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_core.sv
// ============================================================================
// Module  : dmem_core
// Brief   : Word-organised data storage with per-byte-lane write enables and
//           asynchronous clear of every word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_core #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] idx,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (we[l]) begin
               r_mem[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
         end
      end
   end

   assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/alu_block.sv
// ============================================================================
// Module  : alu_block
// Brief   : EX-stage ALU with registered overflow, ID-stage equality
//           comparator and MEM-stage byte-addressable data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_block
   import mips_pkg::*;
#(
   parameter int DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   input  logic [4:0]  shamt,
   input  logic [3:0]  alu_op,
   output logic [31:0] alu_result,
   output logic        ov,
   input  logic [31:0] cmp_a,
   input  logic [31:0] cmp_b,
   output logic        zero,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_bw
);

   localparam int c_IDX_W = $clog2(DMEM_WORDS);

   logic [31:0] w_sum;
   logic [31:0] w_diff;
   logic        w_add_ov;
   logic        w_sub_ov;
   logic        w_ov_next;
   logic [31:0] w_result;
   logic        r_ov;

   assign w_sum  = alu_a + alu_b;
   assign w_diff = alu_a - alu_b;

   always_comb begin
      w_result = '0;
      case (alu_op)
         ALU_ADD, ALU_ADDU: w_result = w_sum;
         ALU_SUB, ALU_SUBU: w_result = w_diff;
         ALU_AND:  w_result = alu_a & alu_b;
         ALU_OR:   w_result = alu_a | alu_b;
         ALU_XOR:  w_result = alu_a ^ alu_b;
         ALU_NOR:  w_result = ~(alu_a | alu_b);
         ALU_SLT:  w_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: w_result = {31'd0, alu_a < alu_b};
         ALU_SLL:  w_result = alu_b << shamt;
         ALU_SRL:  w_result = alu_b >> shamt;
         ALU_SRA:  w_result = $unsigned($signed(alu_b) >>> shamt);
         ALU_LUI:  w_result = {alu_b[15:0], 16'h0000};
         ALU_SLLV: w_result = alu_b << alu_a[4:0];
         ALU_SRLV: w_result = alu_b >> alu_a[4:0];
         default:  w_result = '0;
      endcase
   end

   assign alu_result = w_result;

   // Signed overflow only for the checked ADD/SUB; the flag tracks the current op, never sticky.
   assign w_add_ov  = (alu_a[31] == alu_b[31]) && (w_sum[31]  != alu_a[31]);
   assign w_sub_ov  = (alu_a[31] != alu_b[31]) && (w_diff[31] != alu_a[31]);
   assign w_ov_next = (alu_op == ALU_ADD) ? w_add_ov :
                      (alu_op == ALU_SUB) ? w_sub_ov : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ov <= 1'b0;
      end else begin
         r_ov <= w_ov_next;
      end
   end

   assign ov   = r_ov;
   assign zero = (cmp_a == cmp_b);

   logic [c_IDX_W-1:0] w_idx;
   logic [1:0]         w_lane;
   logic [3:0]         w_we;
   logic [31:0]        w_wdata;
   logic [31:0]        w_word;
   logic [31:0]        w_byte;
   logic               w_unused_addr;

   assign w_idx         = mem_addr[c_IDX_W+1:2];
   assign w_lane        = mem_addr[1:0];
   assign w_unused_addr = ^mem_addr[31:c_IDX_W+2];

   // Byte stores replicate the low byte to all lanes; the enable picks the lane.
   assign w_wdata = (mem_bw == MEM_BYTE) ? {4{mem_wdata[7:0]}} : mem_wdata;
   assign w_we    = !mem_write          ? 4'b0000 :
                    (mem_bw == MEM_BYTE) ? (4'b0001 << w_lane) : 4'b1111;

   dmem_core #(
      .DEPTH (DMEM_WORDS),
      .IDX_W (c_IDX_W)
   ) u_dmem (
      .clk   (clk),
      .rst   (rst),
      .idx   (w_idx),
      .we    (w_we),
      .wdata (w_wdata),
      .rdata (w_word)
   );

   assign w_byte    = {24'd0, w_word[8*w_lane +: 8]};
   assign mem_rdata = !mem_read            ? 32'd0  :
                      (mem_bw == MEM_BYTE) ? w_byte : w_word;

endmodule

`default_nettype wire

// File: tb/tb_alu_block.sv
// ============================================================================
// Module  : tb_alu_block
// Brief   : Self-checking bench for alu_block using an expected-value queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_block;
   import mips_pkg::*;

   localparam int DMEM_WORDS = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_a, alu_b, cmp_a, cmp_b, mem_addr, mem_wdata;
   logic [4:0]  shamt;
   logic [3:0]  alu_op;
   logic [31:0] alu_result, mem_rdata;
   logic        ov, zero, mem_read, mem_write, mem_bw;

   always #5 clk = ~clk;

   alu_block #(.DMEM_WORDS(DMEM_WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .shamt      (shamt),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .ov         (ov),
      .cmp_a      (cmp_a),
      .cmp_b      (cmp_b),
      .zero       (zero),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_bw     (mem_bw)
   );

   string       tag_q[$];
   logic [31:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic push_exp(input string tag, input logic [31:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic check_next(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic exp_ov);
      @(negedge clk);
      alu_op = op; alu_a = a; alu_b = b; shamt = sh;
      push_exp({tag, "_res"}, exp_res);
      push_exp({tag, "_ov"}, {31'd0, exp_ov});
      #1 check_next(alu_result);
      @(posedge clk);
      #1 check_next({31'd0, ov});
   endtask

   task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic bw, input logic [31:0] exp_before,
                            input logic [31:0] exp_after);
      @(negedge clk);
      mem_addr = addr; mem_wdata = wd; mem_bw = bw; mem_read = 1'b1; mem_write = 1'b1;
      push_exp({tag, "_before"}, exp_before);
      #1 check_next(mem_rdata);
      push_exp({tag, "_after"}, exp_after);
      @(posedge clk);
      #1 check_next(mem_rdata);
      mem_write = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [31:0] addr, input logic rd,
                           input logic bw, input logic [31:0] exp_val);
      @(negedge clk);
      mem_addr = addr; mem_bw = bw; mem_read = rd; mem_write = 1'b0;
      push_exp(tag, exp_val);
      #1 check_next(mem_rdata);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst = 1'b1;
      alu_a = '0; alu_b = '0; shamt = '0; alu_op = ALU_ADD;
      cmp_a = '0; cmp_b = '0;
      mem_addr = '0; mem_wdata = '0; mem_read = 1'b1; mem_write = 1'b0; mem_bw = MEM_WORD;
      repeat (3) @(posedge clk);
      #1;
      push_exp("reset_ov", 32'd0);
      check_next({31'd0, ov});
      push_exp("reset_rdata", 32'd0);
      check_next(mem_rdata);
      @(negedge clk);
      rst = 1'b0;

      // ALU directed cases
      run_alu("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
      run_alu("addu_nov", ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0);
      run_alu("sub_ovf",  ALU_SUB,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1);
      run_alu("sub_ok",   ALU_SUB,  32'h5,         32'h7, 5'd0, 32'hFFFF_FFFE, 1'b0);
      run_alu("add_neg",  ALU_ADD,  32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0, 1'b1);
      run_alu("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0);
      run_alu("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
      run_alu("sra",      ALU_SRA,  32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
      run_alu("srl",      ALU_SRL,  32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
      run_alu("sll",      ALU_SLL,  32'h0,         32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
      run_alu("lui",      ALU_LUI,  32'h0,         32'hFFFF_1234, 5'd0, 32'h1234_0000, 1'b0);
      run_alu("nor",      ALU_NOR,  32'hF0F0_0000, 32'h0000_000F, 5'd0, 32'h0F0F_FFF0, 1'b0);
      run_alu("and",      ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b0);
      run_alu("or",       ALU_OR,   32'hFF00_0000, 32'h0000_00FF, 5'd0, 32'hFF00_00FF, 1'b0);
      run_alu("sllv",     ALU_SLLV, 32'hFFFF_FFE4, 32'h1, 5'd0, 32'h10, 1'b0);
      run_alu("srlv",     ALU_SRLV, 32'h0000_0028, 32'h8000_0000, 5'd0, 32'h0080_0000, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         case (i % 3)
            0: run_alu("rand_addu", ALU_ADDU, ra, rb, 5'd0, ra + rb, 1'b0);
            1: run_alu("rand_subu", ALU_SUBU, ra, rb, 5'd0, ra - rb, 1'b0);
            default: run_alu("rand_xor", ALU_XOR, ra, rb, 5'd0, ra ^ rb, 1'b0);
         endcase
      end

      // Comparator
      @(negedge clk);
      cmp_a = 32'hDEAD_BEEF; cmp_b = 32'hDEAD_BEEF;
      push_exp("cmp_eq", 32'd1);
      #1 check_next({31'd0, zero});
      cmp_b = 32'hDEAD_BEEE;
      push_exp("cmp_ne", 32'd0);
      #1 check_next({31'd0, zero});

      // Data memory
      run_store("st_word",  32'h10,  32'hAABB_CCDD, MEM_WORD, 32'h0, 32'hAABB_CCDD);
      run_load ("ld_word",  32'h10,  1'b1, MEM_WORD, 32'hAABB_CCDD);
      run_load ("ld_unal",  32'h12,  1'b1, MEM_WORD, 32'hAABB_CCDD);
      run_load ("ld_b1",    32'h11,  1'b1, MEM_BYTE, 32'h0000_00CC);
      run_load ("ld_b0",    32'h10,  1'b1, MEM_BYTE, 32'h0000_00DD);
      run_store("st_byte",  32'h13,  32'hFFFF_FF55, MEM_BYTE, 32'h0000_00AA, 32'h0000_0055);
      run_load ("ld_after_sb", 32'h10, 1'b1, MEM_WORD, 32'h55BB_CCDD);
      run_store("st_wrap",  32'h400, 32'h1234_5678, MEM_WORD, 32'h0, 32'h1234_5678);
      run_load ("ld_wrap",  32'h000, 1'b1, MEM_WORD, 32'h1234_5678);
      run_load ("rd_off",   32'h10,  1'b0, MEM_WORD, 32'h0);

      // Asynchronous reset mid-run with ov set and a store held during reset
      run_alu("pre_rst_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      push_exp("rst_async_ov", 32'd0);
      #1 check_next({31'd0, ov});
      alu_op = ALU_ADDU; alu_a = '0; alu_b = '0;
      mem_addr = 32'h20; mem_wdata = 32'hCAFE_F00D; mem_bw = MEM_WORD;
      mem_read = 1'b1; mem_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      rst = 1'b0;
      run_load("rst_clr_10",   32'h10, 1'b1, MEM_WORD, 32'h0);
      run_load("rst_clr_00",   32'h00, 1'b1, MEM_WORD, 32'h0);
      run_load("rst_drop_st",  32'h20, 1'b1, MEM_WORD, 32'h0);
      run_load("rst_clr_byte", 32'h13, 1'b1, MEM_BYTE, 32'h0);
      @(posedge clk);
      #1;
      push_exp("post_rst_ov", 32'd0);
      check_next({31'd0, ov});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
